// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default constants for the fetch-stage PC generator.
// Used by pc_gen and pc_redirect_buf.

package pc_pkg;

    // Default parameter values for pc_gen.
    localparam int          PC_W_DEF    = 32;
    localparam logic [31:0] RST_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] INC_DEF     = 32'd4;

    // Control FSM states: OFF after reset, RUN while fetching, HALT when parked.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Why pc was loaded from a target at the coming edge, if at all.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        EXC    = 2'd2
    } redirect_cause_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry pending branch-target register.
// Captures a branch that arrives while fetch is stalled so it can be applied on
// the first unstalled edge. A newer set overwrites the held target; clear wins
// over set so an exception or a consumed redirect always empties the buffer.

module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set,
    input  logic            clr,
    input  logic [PC_W-1:0] target,
    output logic            valid,
    output logic [PC_W-1:0] pend_target
);

    // Pending flag and held target; clear has priority over set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid       <= 1'b0;
            pend_target <= '0;
        end else if (clr) begin
            valid       <= 1'b0;
        end else if (set) begin
            valid       <= 1'b1;
            pend_target <= target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
// Drives the instruction-ROM address (pc) and enable (ce) with stall, branch,
// exception and halt/resume control. All outputs come straight from flops.
// Optional feature macro: PC_PEND_REDIRECT_EN -- when defined, a branch seen
// during a stall is parked in pc_redirect_buf and applied once the stall ends;
// when undefined, a branch overrides the stall and loads immediately.
// INC must be nonzero and fit in PC_W bits.

module pc_gen
    import pc_pkg::*;
#(
    parameter int            PC_W    = PC_W_DEF,
    parameter logic [PC_W-1:0] RST_VEC = PC_W'(RST_VEC_DEF),
    parameter logic [PC_W-1:0] INC     = PC_W'(INC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_flag,
    input  logic [PC_W-1:0] branch_target,
    input  logic            exc_flag,
    input  logic [PC_W-1:0] exc_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic            ce,
    output logic            halted,
    output logic            redirected
);

    pc_state_e       state_q, state_d;
    redirect_cause_e cause;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ce_q, halted_q, redir_q;
    logic            pend_set, pend_clr;

`ifdef PC_PEND_REDIRECT_EN
    logic            pend_valid;
    logic [PC_W-1:0] pend_target;

    pc_redirect_buf #(
        .PC_W (PC_W)
    ) u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .set         (pend_set),
        .clr         (pend_clr),
        .target      (branch_target),
        .valid       (pend_valid),
        .pend_target (pend_target)
    );
`endif

    // Next-state and next-pc selection by strict priority: exception, branch,
    // stall, sequential increment.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        pc_d     = pc_q;
        cause    = NONE;
        pend_set = 1'b0;
        pend_clr = 1'b0;

        unique case (state_q)
            OFF: begin
                // Requests are ignored; first edge out of reset starts fetch
                // at RST_VEC.
                state_d = RUN;
            end

            RUN: begin
                if (exc_flag) begin
                    pc_d     = exc_target;
                    cause    = EXC;
                    pend_clr = 1'b1;
                end else begin
                    if (halt_req) state_d = HALT;
`ifdef PC_PEND_REDIRECT_EN
                    if (branch_flag && stall) begin
                        pend_set = 1'b1;
                    end else if (branch_flag) begin
                        // A fresh branch on the release cycle beats the parked one.
                        pc_d     = branch_target;
                        cause    = BRANCH;
                        pend_clr = 1'b1;
                    end else if (!stall && pend_valid) begin
                        pc_d     = pend_target;
                        cause    = BRANCH;
                        pend_clr = 1'b1;
                    end else if (!stall && !halt_req) begin
                        pc_d = pc_q + INC;
                    end
`else
                    if (branch_flag) begin
                        pc_d  = branch_target;
                        cause = BRANCH;
                    end else if (!stall && !halt_req) begin
                        pc_d = pc_q + INC;
                    end
`endif
                end
            end

            HALT: begin
                if (exc_flag) begin
                    state_d  = RUN;
                    pc_d     = exc_target;
                    cause    = EXC;
                    pend_clr = 1'b1;
                end else if (resume) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = OFF;
            end
        endcase
    end

`ifndef PC_PEND_REDIRECT_EN
    // Without the pending buffer these controls have no consumer.
    logic unused_pend;
    assign unused_pend = pend_set ^ pend_clr;
`endif

    // State, pc and the registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= OFF;
            pc_q     <= RST_VEC;
            ce_q     <= 1'b0;
            halted_q <= 1'b0;
            redir_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q  <= state_d;
            pc_q     <= pc_d;
            ce_q     <= (state_d == RUN);
            halted_q <= (state_d == HALT);
            redir_q  <= (cause != NONE);
        end
    end

    assign pc         = pc_q;
    assign ce         = ce_q;
    assign halted     = halted_q;
    assign redirected = redir_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen (PC_W=8, RST_VEC=0x10, INC=4).
// Directed scenarios for reset, stall, priority, wrap, halt/resume and
// branch-during-stall, then a randomized run checked against a cycle model.

module tb_pc_gen;

    localparam int          W    = 8;
    localparam logic [W-1:0] RV  = 8'h10;
    localparam int          STEP = 4;
`ifdef PC_PEND_REDIRECT_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stall = 1'b0;
    logic         branch_flag = 1'b0;
    logic [W-1:0] branch_target = '0;
    logic         exc_flag = 1'b0;
    logic [W-1:0] exc_target = '0;
    logic         halt_req = 1'b0;
    logic         resume = 1'b0;
    logic [W-1:0] pc;
    logic         ce, halted, redirected;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: fetch address as a plain integer plus a few flags.
    bit m_started, m_halted, m_redir, m_pend;
    int m_pc, m_pend_tgt;

    pc_gen #(
        .PC_W    (W),
        .RST_VEC (RV),
        .INC     (8'(STEP))
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .exc_flag      (exc_flag),
        .exc_target    (exc_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc            (pc),
        .ce            (ce),
        .halted        (halted),
        .redirected    (redirected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_redir   = 1'b0;
        m_pend    = 1'b0;
        m_pc      = int'(RV);
        m_pend_tgt = 0;
    endtask

    // What one rising edge does, given the inputs currently applied.
    task automatic model_edge();
        bit r = 1'b0;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (exc_flag) begin
            m_pc = int'(exc_target); r = 1'b1; m_halted = 1'b0; m_pend = 1'b0;
        end else if (m_halted) begin
            if (resume) m_halted = 1'b0;
        end else begin
            if (halt_req) m_halted = 1'b1;
            if (branch_flag && stall && PEND) begin
                m_pend = 1'b1; m_pend_tgt = int'(branch_target);
            end else if (branch_flag) begin
                m_pc = int'(branch_target); r = 1'b1; m_pend = 1'b0;
            end else if (stall) begin
                // frozen
            end else if (m_pend) begin
                m_pc = m_pend_tgt; r = 1'b1; m_pend = 1'b0;
            end else if (!halt_req) begin
                m_pc = (m_pc + STEP) % (1 << W);
            end
        end
        m_redir = r;
    endtask

    task automatic check_model(input string where);
        check({where, "_pc"},     32'(pc),         32'(m_pc));
        check({where, "_ce"},     32'(ce),         32'(m_started && !m_halted));
        check({where, "_halted"}, 32'(halted),     32'(m_halted));
        check({where, "_redir"},  32'(redirected), 32'(m_redir));
    endtask

    // Advance one clock edge, update the model and compare just after the edge.
    task automatic step(input string where);
        @(posedge clk);
        model_edge();
        #1;
        check_model(where);
    endtask

    task automatic idle_inputs();
        stall = 0; branch_flag = 0; exc_flag = 0; halt_req = 0; resume = 0;
    endtask

    initial begin
        model_reset();
        // Reset held low: outputs at reset values.
        #12;
        check("rst_pc", 32'(pc), 32'h10);
        check("rst_ce", 32'(ce), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_redir", 32'(redirected), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Reset release: RST_VEC fetched first, then sequential.
        step("edge1");
        check("edge1_pc", 32'(pc), 32'h10);
        check("edge1_ce", 32'(ce), 32'h1);
        step("edge2");
        check("edge2_pc", 32'(pc), 32'h14);
        step("edge3");
        check("edge3_pc", 32'(pc), 32'h18);

        // Three stalled cycles hold pc.
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check("stall_hold", 32'(pc), 32'h18);
        end
        // Exception beats branch.
        stall = 0; branch_flag = 1; branch_target = 8'h40; exc_flag = 1; exc_target = 8'h80;
        step("prio");
        check("prio_pc", 32'(pc), 32'h80);
        check("prio_redir", 32'(redirected), 32'h1);
        idle_inputs();
        step("prio_after");
        check("prio_redir_drop", 32'(redirected), 32'h0);

        // Wrap from 0xFC.
        branch_flag = 1; branch_target = 8'hFC;
        step("to_fc");
        idle_inputs();
        step("wrap");
        check("wrap_pc", 32'(pc), 32'h00);
        check("wrap_redir", 32'(redirected), 32'h0);

        // Halt at 0x20, branch ignored while halted, then resume.
        branch_flag = 1; branch_target = 8'h20;
        step("to_20");
        idle_inputs(); halt_req = 1;
        step("halt");
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_ce", 32'(ce), 32'h0);
        check("halt_pc", 32'(pc), 32'h20);
        idle_inputs(); branch_flag = 1; branch_target = 8'h99;
        step("halt_br");
        check("halt_br_pc", 32'(pc), 32'h20);
        idle_inputs(); resume = 1;
        step("resume");
        check("resume_ce", 32'(ce), 32'h1);
        check("resume_pc", 32'(pc), 32'h20);
        idle_inputs();
        step("resume2");
        check("resume2_pc", 32'(pc), 32'h24);

        // Branch during stall.
        stall = 1; branch_flag = 1; branch_target = 8'h60;
        step("br_stall");
        idle_inputs();
        step("br_release");
`ifdef PC_PEND_REDIRECT_EN
        check("br_release_pc", 32'(pc), 32'h60);
        check("br_release_redir", 32'(redirected), 32'h1);
`else
        check("br_release_pc", 32'(pc), 32'h64);
        check("br_release_redir", 32'(redirected), 32'h0);
`endif

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            stall         = ($urandom_range(3) == 0);
            branch_flag   = ($urandom_range(7) == 0);
            branch_target = 8'($urandom);
            exc_flag      = ($urandom_range(15) == 0);
            exc_target    = 8'($urandom);
            halt_req      = ($urandom_range(15) == 0);
            resume        = ($urandom_range(3) == 0);
            step("rand");
        end

        // Async reset mid-stall with a branch possibly parked.
        idle_inputs(); stall = 1; branch_flag = 1; branch_target = 8'h60;
        step("pre_rst");
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("async_pc", 32'(pc), 32'h10);
        check("async_ce", 32'(ce), 32'h0);
        check("async_halted", 32'(halted), 32'h0);
        check("async_redir", 32'(redirected), 32'h0);
        @(posedge clk);
        #1;
        check_model("in_rst");
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        step("post_rst1");
        check("post_rst1_pc", 32'(pc), 32'h10);
        step("post_rst2");
        check("post_rst2_pc", 32'(pc), 32'h14);
        check("post_rst2_redir", 32'(redirected), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
